// File: rtl/led_bar_sequencer.sv
// LED-bar pattern sequencer: steps a position every TICK_DIV cycles and decodes FILL/DRAIN/CHASE/BOUNCE.
// Start takes effect on the next edge; LEDs are decoded combinationally from registered state; pause freezes the run.
module led_bar_sequencer #(
  parameter int N_LEDS   = 16,
  parameter int TICK_DIV = 80_000_000,
  parameter int CNT_W    = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic [1:0]        mode_i,
  input  logic              loop_i,
  output logic [N_LEDS-1:0] led_o,
  output logic              busy_o,
  output logic              finish_o,
  output logic              step_pulse_o
);

  localparam int                PW       = (N_LEDS > 2) ? $clog2(N_LEDS) : 1;
  localparam logic [PW-1:0]     POS_LAST = PW'(N_LEDS - 1);
  localparam logic [PW-1:0]     POS_ONE  = PW'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [N_LEDS-1:0] ONES     = '1;
  localparam logic [N_LEDS-1:0] ONE      = N_LEDS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    M_FILL   = 2'd0,
    M_DRAIN  = 2'd1,
    M_CHASE  = 2'd2,
    M_BOUNCE = 2'd3
  } mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;   // 1 = moving down (BOUNCE only)

  logic          tick;
  logic          last_step;
  logic [PW-1:0] pos_inc;

  assign pos_inc   = pos_q + POS_ONE;
  assign tick      = (state_q == S_RUN) && !pause_i && (cnt_q == CNT_LAST);
  assign last_step = (mode_q == M_BOUNCE) ? (dir_q && (pos_q == POS_ONE))
                                          : (pos_q == POS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_FILL;
      pos_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_RUN;
          mode_d  = mode_e'(mode_i);
          pos_d   = '0;
          cnt_d   = '0;
          dir_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (!pause_i) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (last_step) begin
              // loop is only looked at here, on the final step of a sequence
              if (loop_i) begin
                pos_d = '0;
                dir_d = 1'b0;
              end else begin
                state_d = S_DONE;
              end
            end else if (mode_q == M_BOUNCE) begin
              if (dir_q) begin
                pos_d = pos_q - POS_ONE;
              end else begin
                pos_d = pos_inc;
                if (pos_inc == POS_LAST) dir_d = 1'b1;
              end
            end else begin
              pos_d = pos_inc;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // DONE keeps decoding the held position so the last pattern stays lit
  always_comb begin
    led_o = '0;
    if (state_q != S_IDLE) begin
      case (mode_q)
        M_FILL:  led_o = ONES >> (POS_LAST - pos_q);
        M_DRAIN: led_o = ONES >> pos_q;
        default: led_o = ONE << pos_q;
      endcase
    end
  end

  assign busy_o       = (state_q == S_RUN);
  assign finish_o     = (state_q == S_DONE);
  assign step_pulse_o = tick;

endmodule

// File: tb/tb_led_bar_sequencer.sv
// Bench for led_bar_sequencer: directed and randomized runs checked against a step-list reference model.
module tb_led_bar_sequencer;
  localparam int N  = 8;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, loop = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] led;
  logic       busy, finish, step_pulse;

  logic       start1 = 1'b0, pause1 = 1'b0, loop1 = 1'b0;
  logic [1:0] mode1 = 2'd0;
  logic [7:0] led1;
  logic       busy1, finish1, step_pulse1;

  always #5 clk = ~clk;

  led_bar_sequencer #(.N_LEDS(N), .TICK_DIV(TD), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .pause_i(pause), .mode_i(mode),
    .loop_i(loop), .led_o(led), .busy_o(busy), .finish_o(finish), .step_pulse_o(step_pulse)
  );

  led_bar_sequencer #(.N_LEDS(N), .TICK_DIV(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .pause_i(pause1), .mode_i(mode1),
    .loop_i(loop1), .led_o(led1), .busy_o(busy1), .finish_o(finish1), .step_pulse_o(step_pulse1)
  );

  int total = 0;
  int bad = 0;

  // Reference model: phase 0 idle / 1 running / 2 done, index into the step list, cycles spent in step
  int ph = 0, mq = 0, k = 0, c = 0;
  int seq[$];
  int pulses = 0, seen8 = 0;

  function automatic logic [7:0] pattern(input int md, input int p);
    int v;
    case (md)
      0:       v = (1 << (p + 1)) - 1;
      1:       v = 255 >> p;
      default: v = 1 << p;
    endcase
    return v[7:0];
  endfunction

  function automatic void build(input int md);
    seq.delete();
    for (int p = 0; p < N; p++) seq.push_back(p);
    if (md == 3) for (int p = N - 2; p >= 1; p--) seq.push_back(p);
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, got, exp);
    end
  endtask

  task automatic cycle(input string tag);
    logic [7:0] e_led;
    logic       e_sp;
    @(negedge clk);
    e_led = 8'h00;
    if (ph != 0) e_led = pattern(mq, seq[k]);
    e_sp = (ph == 1) && !pause && (c == TD - 1);
    chk(tag, "led", 32'(led), 32'(e_led));
    chk(tag, "busy", 32'(busy), 32'(ph == 1));
    chk(tag, "finish", 32'(finish), 32'(ph == 2));
    chk(tag, "step_pulse", 32'(step_pulse), 32'(e_sp));
    if (step_pulse) pulses++;
    if (led == 8'h08) seen8++;
    @(posedge clk);
    if (ph != 1) begin
      if (start) begin
        ph = 1; mq = int'(mode); build(mq); k = 0; c = 0;
      end
    end else if (!pause) begin
      if (c == TD - 1) begin
        c = 0;
        if (k == seq.size() - 1) begin
          if (loop) k = 0;
          else ph = 2;
        end else begin
          k++;
        end
      end else begin
        c++;
      end
    end
    #1;
  endtask

  task automatic go(input int md, input logic lp, input string tag);
    mode = 2'(md); loop = lp; start = 1'b1;
    cycle(tag);
    start = 1'b0;
  endtask

  task automatic run_until_done(input int maxc, input string tag);
    for (int i = 0; i < maxc && ph != 2; i++) cycle(tag);
    chk(tag, "done_in_bound", 32'(ph == 2), 32'd1);
  endtask

  initial begin
    // 1: reset values and idle behaviour
    #3;
    chk("t1", "rst_led", 32'(led), 32'h0);
    chk("t1", "rst_busy", 32'(busy), 32'h0);
    chk("t1", "rst_finish", 32'(finish), 32'h0);
    chk("t1", "rst_step", 32'(step_pulse), 32'h0);
    chk("t1", "rst_led1", 32'(led1), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) cycle("t1");
    chk("t1", "no_pulses", 32'(pulses), 32'd0);

    // 2: FILL one-shot, finish exactly 32 cycles after acceptance
    pulses = 0;
    go(0, 1'b0, "t2");
    for (int i = 0; i < 31; i++) cycle("t2");
    chk("t2", "finish_at_31", 32'(finish), 32'h0);
    cycle("t2");
    chk("t2", "finish_at_32", 32'(finish), 32'h1);
    chk("t2", "busy_at_32", 32'(busy), 32'h0);
    chk("t2", "led_at_32", 32'(led), 32'hFF);
    chk("t2", "pulses", 32'(pulses), 32'd8);
    for (int i = 0; i < 5; i++) cycle("t2");

    // 3: DRAIN one-shot, then a fresh start from DONE
    go(1, 1'b0, "t3");
    run_until_done(60, "t3");
    for (int i = 0; i < 4; i++) cycle("t3");
    chk("t3", "led_hold", 32'(led), 32'h01);

    // 4: BOUNCE looping for three full sequences, then let it finish
    go(3, 1'b1, "t4");
    for (int i = 0; i < 3 * 14 * TD; i++) cycle("t4");
    loop = 1'b0;
    run_until_done(80, "t4");
    chk("t4", "led_end", 32'(led), 32'h02);

    // 5: CHASE with a 10-cycle pause at pos 3 and a start ignored mid-run
    go(2, 1'b0, "t5");
    for (int i = 0; i < 100 && !(k == 3 && c == 1); i++) cycle("t5");
    chk("t5", "reach_pos3", 32'(led), 32'h08);
    seen8 = 0;
    seen8 = 0;
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      cycle("t5p");
    end
    start = 1'b0;
    pause = 1'b0;
    for (int i = 0; i < 100 && ph == 1; i++) cycle("t5");
    chk("t5", "pos3_visible", 32'(seen8 + 1), 32'd14);
    chk("t5", "led_end", 32'(led), 32'h80);

    // 6a: start from DONE switches to the new mode and clears finish
    go(1, 1'b0, "t6");
    chk("t6", "finish_clr", 32'(finish), 32'h0);
    chk("t6", "new_mode_led", 32'(led), 32'hFF);

    // 6b: asynchronous reset at pos 5
    for (int i = 0; i < 100 && !(k == 5 && c == 2); i++) cycle("t6");
    #2 rst_n = 1'b0;
    #1;
    chk("t6", "async_led", 32'(led), 32'h0);
    chk("t6", "async_busy", 32'(busy), 32'h0);
    ph = 0;
    cycle("t6r"); cycle("t6r");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t6r");

    // randomized runs: random mode/loop, random pauses and stray starts
    for (int r = 0; r < 8; r++) begin
      int len;
      go(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd");
      len = int'($urandom_range(20, 150));
      for (int i = 0; i < len; i++) begin
        pause = ($urandom_range(0, 4) == 0);
        start = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 29) == 0) loop = ~loop;
        cycle("rnd");
      end
      pause = 1'b0; start = 1'b0; loop = 1'b0;
      run_until_done(200, "rnd");
    end

    // 6c: TICK_DIV=1 instance gives a new FILL pattern every cycle
    mode1 = 2'd0; loop1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("t6d1", "led", 32'(led1), 32'(pattern(0, i)));
      chk("t6d1", "step", 32'(step_pulse1), 32'h1);
      @(posedge clk); #1;
    end
    chk("t6d1", "finish", 32'(finish1), 32'h1);
    chk("t6d1", "led_hold", 32'(led1), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
